// File: rtl/mm_step_sequencer_if.sv
// rtl/mm_step_sequencer_if.sv - host and step-controller handshake bundle for mm_step_sequencer
interface mm_step_sequencer_if #(
   parameter int SW = 3
);
   logic          GO;
   logic          EOM;
   logic          STM;
   logic          LD;
   logic          ACC_CLR;
   logic          SHF;
   logic [SW-1:0] STEP;
   logic          BUSY;
   logic          DONE;
   logic          ERR;

   modport master (
      input  GO, EOM,
      output STM, LD, ACC_CLR, SHF, STEP, BUSY, DONE, ERR
   );

   modport slave (
      output GO, EOM,
      input  STM, LD, ACC_CLR, SHF, STEP, BUSY, DONE, ERR
   );
endinterface

// File: rtl/mm_step_sequencer.sv
// rtl/mm_step_sequencer.sv - STM/EOM initiator issuing N multiply steps per job; EOM wait timeout under MM_STEP_SEQUENCER_TIMEOUT_EN
module mm_step_sequencer #(
   parameter int N   = 4,
   parameter int SW  = 3,
   parameter int TMO = 15
) (
   input logic                 CLK,
   input logic                 RST,
   mm_step_sequencer_if.master bus
);
   typedef enum logic [2:0] {
      IDLE, LOAD, START, WAIT_BUSY, WAIT_DONE, SHIFT, FIN
   } state_t;

   state_t        state, state_nx;
   logic [SW-1:0] step;
   logic          tmo_hit;
   logic          waiting;
   logic          last_step;

   if (N < 2 || (1 << SW) <= N - 1 || TMO < 1) begin : g_bad_param
      $error("mm_step_sequencer: illegal parameter combination");
   end

   assign waiting   = (state == WAIT_BUSY) || (state == WAIT_DONE);
   assign last_step = (step == SW'(N - 1));

`ifdef MM_STEP_SEQUENCER_TIMEOUT_EN
   localparam int CW = $clog2(TMO + 1);
   logic [CW-1:0] wcnt;
   logic          err;

   // Fires on the TMO-th consecutive wait cycle after STM.
   assign tmo_hit = waiting && (wcnt == CW'(TMO - 1));

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         wcnt <= '0;
         err  <= 1'b0;
      end else begin
         if (state == START)
            wcnt <= '0;
         else if (waiting)
            wcnt <= wcnt + 1'b1;

         if (state == IDLE && bus.GO)
            err <= 1'b0;
         else if (tmo_hit && !(state == WAIT_BUSY ? !bus.EOM : bus.EOM))
            err <= 1'b1;
      end
   end

   assign bus.ERR = err;
`else
   assign tmo_hit = 1'b0;
   assign bus.ERR = 1'b0;
`endif

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state <= IDLE;
         step  <= '0;
      end else begin
         state <= state_nx;
         if (state == IDLE && bus.GO)
            step <= '0;
         else if (state == SHIFT)
            step <= step + 1'b1;
      end
   end

   // An EOM edge arriving on the timeout cycle still counts as progress.
   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:      if (bus.GO) state_nx = LOAD;
         LOAD:      state_nx = START;
         START:     state_nx = WAIT_BUSY;
         WAIT_BUSY: begin
            if (!bus.EOM)
               state_nx = WAIT_DONE;
            else if (tmo_hit)
               state_nx = IDLE;
         end
         WAIT_DONE: begin
            if (bus.EOM)
               state_nx = last_step ? FIN : SHIFT;
            else if (tmo_hit)
               state_nx = IDLE;
         end
         SHIFT:     state_nx = START;
         FIN:       state_nx = IDLE;
         default:   state_nx = IDLE;
      endcase
   end

   assign bus.STM     = (state == START);
   assign bus.LD      = (state == LOAD);
   assign bus.ACC_CLR = (state == LOAD);
   assign bus.SHF     = (state == SHIFT);
   assign bus.BUSY    = (state != IDLE);
   assign bus.DONE    = (state == FIN);
   assign bus.STEP    = step;
endmodule

// File: tb/tb_mm_step_sequencer.sv
// tb/tb_mm_step_sequencer.sv - cycle model and directed jobs for mm_step_sequencer
module tb_mm_step_sequencer;
   localparam int N   = 4;
   localparam int SW  = 3;
   localparam int TMO = 15;

   logic CLK = 1'b0;
   logic RST = 1'b0;

   mm_step_sequencer_if #(.SW(SW)) bus ();

   mm_step_sequencer #(.N(N), .SW(SW), .TMO(TMO)) dut (
      .CLK (CLK),
      .RST (RST),
      .bus (bus)
   );

   always #5 CLK = ~CLK;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int lat   = 3;
   bit chk_en = 1'b1;
   int q_stm[$], q_shf[$], q_done[$], q_ld[$];

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", name, act, exp);
      end
   endtask

   function automatic int pack(input logic stm, ld, clr, shf, busy, done, err,
                               input logic [SW-1:0] step);
      return int'({stm, ld, clr, shf, busy, done, err, step});
   endfunction

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge CLK);
         #1;
      end
   endtask

   task automatic clear_q();
      q_stm.delete(); q_shf.delete(); q_done.delete(); q_ld.delete();
   endtask

   initial forever begin
      @(posedge CLK);
      cyc++;
   end

   // Behavioural step controller: EOM low for lat cycles starting after STM; lat=0 never answers.
   initial begin : ctrl
      int rem;
      rem = 0;
      bus.EOM = 1'b1;
      forever begin
         @(negedge CLK);
         if (bus.STM && lat > 0) rem = lat;
         @(posedge CLK);
         #1;
         if (!RST) rem = 0;
         if (rem > 0) begin
            bus.EOM = 1'b0;
            rem--;
         end else begin
            bus.EOM = 1'b1;
         end
      end
   end

   // Job model: offset t from the GO cycle; each step is lat+3 cycles, the last ends in FIN.
   initial begin : model
      bit            job_on;
      int            g, jl, t, p, d, u, k, r;
      logic [SW-1:0] last_step;
      logic          e_stm, e_ld, e_shf, e_busy, e_done;
      logic [SW-1:0] e_step;
      job_on = 1'b0; g = 0; jl = 3; d = 0; last_step = '0;
      forever begin
         @(negedge CLK);
         if (!RST) begin
            job_on    = 1'b0;
            last_step = '0;
            if (chk_en)
               check($sformatf("reset_c%0d", cyc),
                     pack(bus.STM, bus.LD, bus.ACC_CLR, bus.SHF, bus.BUSY, bus.DONE, bus.ERR, bus.STEP), 0);
         end else begin
            e_stm = 0; e_ld = 0; e_shf = 0; e_busy = 0; e_done = 0;
            e_step = last_step;
            if (job_on) begin
               t = cyc - g;
               p = jl + 3;
               d = 2 + (N - 1) * p + jl + 2;
               e_busy = 1'b1;
               if (t == 1) begin
                  e_ld   = 1'b1;
                  e_step = '0;
               end else begin
                  u = t - 2;
                  k = u / p;
                  r = u % p;
                  e_step = SW'(k);
                  e_stm  = (r == 0);
                  e_shf  = (r == jl + 2) && (k < N - 1);
                  e_done = (t == d);
               end
            end
            if (chk_en)
               check($sformatf("c%0d", cyc),
                     pack(bus.STM, bus.LD, bus.ACC_CLR, bus.SHF, bus.BUSY, bus.DONE, bus.ERR, bus.STEP),
                     pack(e_stm, e_ld, e_ld, e_shf, e_busy, e_done, 1'b0, e_step));
            if (!job_on && bus.GO) begin
               job_on = 1'b1;
               g      = cyc;
               jl     = lat;
            end else if (job_on && cyc - g == d) begin
               job_on    = 1'b0;
               last_step = SW'(N - 1);
            end
         end
         if (bus.STM)  q_stm.push_back(cyc);
         if (bus.SHF)  q_shf.push_back(cyc);
         if (bus.DONE) q_done.push_back(cyc);
         if (bus.LD)   q_ld.push_back(cyc);
      end
   end

   initial begin : stim
      int g0;
      bus.GO = 1'b1;
      RST    = 1'b0;
      lat    = 3;
      tick(3);
      check("rst_held_outputs",
            pack(bus.STM, bus.LD, bus.ACC_CLR, bus.SHF, bus.BUSY, bus.DONE, bus.ERR, bus.STEP), 0);
      bus.GO = 1'b0;
      RST    = 1'b1;
      clear_q();
      tick(4);
      check("no_ld_after_rst", q_ld.size(), 0);

      // Nominal job
      clear_q();
      bus.GO = 1'b1;
      g0 = cyc;
      tick(1);
      bus.GO = 1'b0;
      tick(28);
      check("nom_ld_cnt", q_ld.size(), 1);
      if (q_ld.size() == 1) check("nom_ld_at", q_ld[0] - g0, 1);
      check("nom_stm_cnt", q_stm.size(), 4);
      foreach (q_stm[i]) check($sformatf("nom_stm%0d_at", i), q_stm[i] - g0, 2 + 6 * i);
      check("nom_shf_cnt", q_shf.size(), 3);
      foreach (q_shf[i]) check($sformatf("nom_shf%0d_at", i), q_shf[i] - g0, 7 + 6 * i);
      check("nom_done_cnt", q_done.size(), 1);
      if (q_done.size() == 1) check("nom_done_at", q_done[0] - g0, 25);
      check("nom_step_hold", int'(bus.STEP), 3);

      // Slow controller with a stray GO at c5
      lat = 10;
      clear_q();
      bus.GO = 1'b1;
      g0 = cyc;
      tick(1);
      bus.GO = 1'b0;
      tick(4);
      bus.GO = 1'b1;
      tick(1);
      bus.GO = 1'b0;
      tick(60);
      check("slow_ld_cnt", q_ld.size(), 1);
      check("slow_stm_cnt", q_stm.size(), 4);
      check("slow_shf_cnt", q_shf.size(), 3);
      if (q_shf.size() > 0) check("slow_shf0_at", q_shf[0] - g0, 14);
      check("slow_done_cnt", q_done.size(), 1);
      if (q_done.size() == 1) check("slow_done_at", q_done[0] - g0, 53);

      // Reset at c10 mid-job
      lat = 3;
      clear_q();
      bus.GO = 1'b1;
      g0 = cyc;
      tick(1);
      bus.GO = 1'b0;
      tick(9);
      #2;
      RST = 1'b0;
      #1;
      check("midrst_outputs",
            pack(bus.STM, bus.LD, bus.ACC_CLR, bus.SHF, bus.BUSY, bus.DONE, bus.ERR, bus.STEP), 0);
      tick(2);
      RST = 1'b1;
      tick(10);
      check("midrst_done_cnt", q_done.size(), 0);
      check("midrst_ld_cnt", q_ld.size(), 1);
      check("midrst_idle", int'(bus.BUSY), 0);

      // GO held high: back-to-back jobs
      clear_q();
      bus.GO = 1'b1;
      tick(30);
      bus.GO = 1'b0;
      tick(30);
      check("hold_ld_cnt", q_ld.size(), 2);
      check("hold_done_cnt", q_done.size(), 2);
      if (q_ld.size() == 2 && q_done.size() == 2)
         check("hold_ld_after_done", q_ld[1] - q_done[0], 2);

`ifdef MM_STEP_SEQUENCER_TIMEOUT_EN
      // Controller never answers
      chk_en = 1'b0;
      lat = 0;
      clear_q();
      bus.GO = 1'b1;
      g0 = cyc;
      tick(1);
      bus.GO = 1'b0;
      tick(1 + TMO);
      check("tmo_err_before", int'(bus.ERR), 0);
      check("tmo_busy_before", int'(bus.BUSY), 1);
      tick(1);
      check("tmo_err_set", int'(bus.ERR), 1);
      check("tmo_idle", int'(bus.BUSY), 0);
      check("tmo_step_hold", int'(bus.STEP), 0);
      tick(3);
      check("tmo_no_done", q_done.size(), 0);
      check("tmo_err_sticky", int'(bus.ERR), 1);
      lat = 3;
      bus.GO = 1'b1;
      tick(1);
      bus.GO = 1'b0;
      check("tmo_err_cleared", int'(bus.ERR), 0);
      tick(30);
      check("tmo_recover_done", q_done.size(), 1);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
